// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sequencing controller.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic       KIND_ALU = 1'b0;
  localparam logic       KIND_LDI = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  localparam int ONZ_O = 2;
  localparam int ONZ_N = 1;
  localparam int ONZ_Z = 0;

endpackage

// File: rtl/alu_ctrl_regfile.sv
// Operand register file: two combinational read ports, one synchronous write
// port, synchronous active-low clear.
module alu_ctrl_regfile #(
  parameter  int width = 8,
  parameter  int nreg  = 4,
  localparam int IW    = $clog2(nreg)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IW-1:0]    addr_a,
  input  logic [IW-1:0]    addr_b,
  output logic [width-1:0] data_a,
  output logic [width-1:0] data_b,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [width-1:0] wdata
);

  logic [width-1:0] mem [nreg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < nreg; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign data_a = mem[addr_a];
  assign data_b = mem[addr_b];

endmodule

// File: rtl/alu_ctrl.sv
// Multi-cycle controller sequencing an external ALU over a small register file.
// Optional sticky overflow output enabled by ALU_CTRL_STICKY_OVF_EN.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter  int width = 8,
  parameter  int nreg  = 4,
  localparam int IW    = $clog2(nreg)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_kind,
  input  logic [2:0]       in_op,
  input  logic [IW-1:0]    in_rd,
  input  logic [IW-1:0]    in_ra,
  input  logic [IW-1:0]    in_rb,
  input  logic [width-1:0] in_imm,
  output logic [width-1:0] alu_A,
  output logic [width-1:0] alu_B,
  output logic [2:0]       alu_op,
  input  logic [width-1:0] alu_Y,
  input  logic [2:0]       alu_ONZ,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
`ifdef ALU_CTRL_STICKY_OVF_EN
  output logic             ovf_sticky,
`endif
  output logic [2:0]       out_onz
);

  state_t           state;
  logic [2:0]       op_q;
  logic [IW-1:0]    rd_q, ra_q, rb_q;
  logic [width-1:0] rd_data_a, rd_data_b;
  logic             accept;
  logic             rf_we;
  logic [IW-1:0]    rf_waddr;
  logic [width-1:0] rf_wdata;

  assign accept = (state == IDLE) && in_valid;

  // Only two write sources: the immediate at the LDI accept edge, or the ALU
  // result at the end of EXEC. Reset inside the regfile drops in-flight writes.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd_q;
    rf_wdata = alu_Y;
    if (accept && in_kind == KIND_LDI) begin
      rf_we    = 1'b1;
      rf_waddr = in_rd;
      rf_wdata = in_imm;
    end else if (state == EXEC) begin
      rf_we = 1'b1;
    end
  end

  alu_ctrl_regfile #(.width(width), .nreg(nreg)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_a (ra_q),
    .addr_b (rb_q),
    .data_a (rd_data_a),
    .data_b (rd_data_b),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  assign alu_A  = (state == EXEC) ? rd_data_a : '0;
  assign alu_B  = (state == EXEC) ? rd_data_b : '0;
  assign alu_op = (state == EXEC) ? op_q : 3'b000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_onz   <= 3'b000;
      op_q      <= 3'b000;
      rd_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
`ifdef ALU_CTRL_STICKY_OVF_EN
      ovf_sticky <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= in_op;
            rd_q     <= in_rd;
            ra_q     <= in_ra;
            rb_q     <= in_rb;
            in_ready <= 1'b0;
            if (in_kind == KIND_LDI) begin
              out_data  <= in_imm;
              out_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          out_data  <= alu_Y;
          out_onz   <= alu_ONZ;
          out_valid <= 1'b1;
          state     <= RESP;
`ifdef ALU_CTRL_STICKY_OVF_EN
          if (alu_ONZ[ONZ_O]) ovf_sticky <= 1'b1;
`endif
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed, table-driven bench for alu_ctrl with a behavioural 8-bit ALU.
// Sticky-overflow checks are compiled in with ALU_CTRL_STICKY_OVF_EN.
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int NR = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_kind;
  logic [2:0]   in_op;
  logic [1:0]   in_rd, in_ra, in_rb;
  logic [W-1:0] in_imm;
  logic [W-1:0] alu_A, alu_B, alu_Y;
  logic [2:0]   alu_op, alu_ONZ;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_onz;
`ifdef ALU_CTRL_STICKY_OVF_EN
  logic         ovf_sticky;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl #(.width(W), .nreg(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_ra     (in_ra),
    .in_rb     (in_rb),
    .in_imm    (in_imm),
    .alu_A     (alu_A),
    .alu_B     (alu_B),
    .alu_op    (alu_op),
    .alu_Y     (alu_Y),
    .alu_ONZ   (alu_ONZ),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef ALU_CTRL_STICKY_OVF_EN
    .ovf_sticky(ovf_sticky),
`endif
    .out_onz   (out_onz)
  );

  // Reference ALU: ADD/SUB with signed overflow, op2 AND, op3 OR, op4 XOR, else pass A.
  always_comb begin
    logic o;
    alu_Y = alu_A;
    o     = 1'b0;
    case (alu_op)
      3'd0: begin
        alu_Y = alu_A + alu_B;
        o = (alu_A[W-1] == alu_B[W-1]) && (alu_Y[W-1] != alu_A[W-1]);
      end
      3'd1: begin
        alu_Y = alu_A - alu_B;
        o = (alu_A[W-1] != alu_B[W-1]) && (alu_Y[W-1] != alu_A[W-1]);
      end
      3'd2: alu_Y = alu_A & alu_B;
      3'd3: alu_Y = alu_A | alu_B;
      3'd4: alu_Y = alu_A ^ alu_B;
      default: alu_Y = alu_A;
    endcase
    alu_ONZ = {o, alu_Y[W-1], (alu_Y == '0)};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic         kind;
    logic [2:0]   op;
    logic [1:0]   rd, ra, rb;
    logic [W-1:0] imm;
    logic [W-1:0] exp_a, exp_b;
    logic [W-1:0] exp_data;
    logic [2:0]   exp_onz;
    logic         exp_sticky;
  } vec_t;

  vec_t vecs[8];

  task automatic drive_instr(input vec_t v);
    in_kind = v.kind; in_op = v.op; in_rd = v.rd; in_ra = v.ra; in_rb = v.rb; in_imm = v.imm;
  endtask

  // One complete transaction: accept, latency, result, handshake release.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    check({v.name, " in_ready before"}, in_ready, 1);
    drive_instr(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (v.kind == KIND_ALU) begin
      check({v.name, " exec out_valid"}, out_valid, 0);
      check({v.name, " exec in_ready"}, in_ready, 0);
      check({v.name, " alu_op"}, alu_op, v.op);
      check({v.name, " alu_A"}, alu_A, v.exp_a);
      check({v.name, " alu_B"}, alu_B, v.exp_b);
      @(posedge clk); #1;
    end
    check({v.name, " out_valid"}, out_valid, 1);
    check({v.name, " out_data"}, out_data, v.exp_data);
    check({v.name, " out_onz"}, out_onz, v.exp_onz);
    check({v.name, " alu_op idle"}, alu_op, 0);
`ifdef ALU_CTRL_STICKY_OVF_EN
    check({v.name, " ovf_sticky"}, ovf_sticky, v.exp_sticky);
`endif
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({v.name, " released out_valid"}, out_valid, 0);
    check({v.name, " released in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] held_data;
    logic [2:0]   held_onz;
    vec_t v;

    //         name       kind      op    rd    ra    rb    imm   A    B    data  onz     sticky
    vecs[0] = '{"add0",   KIND_ALU, 3'd0, 2'd0, 2'd1, 2'd2, 8'd0,   0,   0,   0, 3'b001, 1'b0};
    vecs[1] = '{"ldi100", KIND_LDI, 3'd0, 2'd1, 2'd0, 2'd0, 8'd100, 0,   0, 100, 3'b001, 1'b0};
    vecs[2] = '{"ldi50",  KIND_LDI, 3'd0, 2'd2, 2'd0, 2'd0, 8'd50,  0,   0,  50, 3'b001, 1'b0};
    vecs[3] = '{"add150", KIND_ALU, 3'd0, 2'd3, 2'd1, 2'd2, 8'd0, 100,  50, 150, 3'b110, 1'b1};
    vecs[4] = '{"sub0",   KIND_ALU, 3'd1, 2'd0, 2'd1, 2'd1, 8'd0, 100, 100,   0, 3'b001, 1'b1};
    vecs[5] = '{"addself",KIND_ALU, 3'd0, 2'd1, 2'd1, 2'd1, 8'd0, 100, 100, 200, 3'b110, 1'b1};
    vecs[6] = '{"op2and", KIND_ALU, 3'd2, 2'd2, 2'd1, 2'd3, 8'd0, 200, 150, 128, 3'b010, 1'b1};
    vecs[7] = '{"subneg", KIND_ALU, 3'd1, 2'd0, 2'd2, 2'd1, 8'd0, 128, 200, 184, 3'b010, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = 1'b0; in_op = '0; in_rd = '0; in_ra = '0; in_rb = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_onz", out_onz, 0);
    check("reset alu_A", alu_A, 0);
`ifdef ALU_CTRL_STICKY_OVF_EN
    check("reset ovf_sticky", ovf_sticky, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure: ADD r3=r1+r2 (200+128=72, O=1 N=0 Z=0), then stall with LDI r0=77 pending.
    v = '{"bp", KIND_ALU, 3'd0, 2'd3, 2'd1, 2'd2, 8'd0, 200, 128, 72, 3'b100, 1'b1};
    @(negedge clk);
    drive_instr(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_kind = KIND_LDI; in_rd = 2'd0; in_imm = 8'd77;
    @(posedge clk); #1;
    held_data = out_data;
    held_onz  = out_onz;
    check("bp out_data", held_data, 72);
    check("bp out_onz", held_onz, 3'b100);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp stall out_valid", out_valid, 1);
      check("bp stall in_ready", in_ready, 0);
      check("bp stall out_data", out_data, held_data);
      check("bp stall out_onz", out_onz, held_onz);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release out_valid", out_valid, 0);
    check("bp release in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp resume out_valid", out_valid, 1);
    check("bp resume out_data", out_data, 77);
    check("bp resume onz kept", out_onz, 3'b100);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp done in_ready", in_ready, 1);

    // Reset during EXEC of ADD r3=r1+r2.
    v = '{"rst", KIND_ALU, 3'd0, 2'd3, 2'd1, 2'd2, 8'd0, 0, 0, 0, 3'b000, 1'b0};
    @(negedge clk);
    drive_instr(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst exec alu_A", alu_A, 200);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst out_data", out_data, 0);
    check("rst out_onz", out_onz, 0);
`ifdef ALU_CTRL_STICKY_OVF_EN
    check("rst ovf_sticky", ovf_sticky, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{"after_rst", KIND_ALU, 3'd0, 2'd0, 2'd3, 2'd3, 8'd0, 0, 0, 0, 3'b001, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Multi-cycle controller that sequences the parameterised ALU (ops on `A`/`B`, result `Y`, flags `ONZ` = {O,N,Z}). It accepts instructions over a valid/ready handshake and reads operands from a small internal register file. It drives the ALU, writes the result back, latches the flags and returns the result over a second valid/ready handshake. The ALU stays a separate instance: the integration wrapper connects the `alu_*` ports to it.

## Interface
- `width`, 8, datapath width; must match the ALU instance.
- `nreg`, 4, register-file entries (power of two, ≥2); index width `IW = $clog2(nreg)`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: controller can accept.
- `in_kind` in 1: 0 = ALU op, 1 = LDI (load immediate).
- `in_op` in 3: ALU opcode, passed through unchanged; 0 = ADD, 1 = SUB.
- `in_rd`, `in_ra`, `in_rb` in IW each: destination and source register indices.
- `in_imm` in width: immediate value for LDI.
- `alu_A`, `alu_B` out width; `alu_op` out 3: ALU operands and opcode.
- `alu_Y` in width; `alu_ONZ` in 3: ALU result and flags (combinational, same cycle).
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `out_data` out width: result value.
- `out_onz` out 3: flag register {O,N,Z}.
- `ovf_sticky` out 1: sticky overflow; only present with the macro (see Configuration).

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - `in_ready`=1.
  - On `in_valid`: latch op, rd, ra and rb.
  - ALU kind → EXEC.
  - LDI: at the accept edge write `rf[rd]=in_imm` and set `out_data=in_imm` → RESP. Flags are unchanged.
- EXEC (exactly 1 cycle)
  - Drive `alu_A=rf[ra]`, `alu_B=rf[rb]`, `alu_op` = latched op.
  - At the end of the cycle capture `alu_Y` into `rf[rd]` and `out_data`, and `alu_ONZ` into the flag register → RESP.
- RESP
  - `out_valid`=1.
  - On `out_ready` → IDLE.
  - `out_data` and `out_onz` stay stable while stalled.
- `in_ready` is 1 in IDLE only. `in_valid` is ignored in EXEC and RESP; no queueing.
- Outside EXEC, `alu_A`, `alu_B` and `alu_op` are 0.
- Sources are read in EXEC before the write-back, so rd==ra or rd==rb uses the old values.
- Any register may be the destination; no register is hard-wired to zero.
- Opcodes 2–7 are forwarded unchanged; the controller does not decode them.

## Timing
- Reset: state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_onz`=3'b000, all rf entries 0, `alu_*`=0, `ovf_sticky`=0.
- ALU instruction accepted at edge t → EXEC during cycle t+1 → `out_valid` high in cycle t+2.
- LDI accepted at edge t → `out_valid` high in cycle t+1.
- The earliest next accept is the cycle after the `out_valid && out_ready` edge. Peak rate is one ALU op per 3 cycles and one LDI per 2 cycles.
- Reset asserted in any state: the next edge returns to the reset values. An instruction in flight is dropped and `rf[rd]` is not written.

## Configuration
- `ALU_CTRL_STICKY_OVF_EN` defined:
  - port `ovf_sticky` exists.
  - It is set on the EXEC write-back edge when `alu_ONZ[2]`=1.
  - It is cleared only by reset.
- Not defined: the port and its register are absent; all other behaviour is identical.

## Structure
- `alu_ctrl_pkg`:
  - state enum `state_t` {IDLE, EXEC, RESP}.
  - kind constants `KIND_ALU`=1'b0, `KIND_LDI`=1'b1.
  - opcode constants `OP_ADD`=3'b000, `OP_SUB`=3'b001.
  - flag bit indices `ONZ_O`=2, `ONZ_N`=1, `ONZ_Z`=0.
- Sub-module `alu_ctrl_regfile`:
  - `nreg`×`width`, two combinational read ports, one synchronous write port.
  - synchronous active-low clear to all zeros.

## Test plan
- Reset, then ALU ADD r0=r1+r2 → `out_data`=0, `out_onz`=3'b001; `out_valid` rises 2 cycles after accept.
- LDI r1=100, LDI r2=50, ADD r3=r1+r2 → each LDI responds 1 cycle after accept with `out_data`=100 and 50. The ADD gives `out_data`=150 (0x96), `out_onz`=3'b110.
- SUB r0=r1-r1 with r1=100 → `out_data`=0, `out_onz`=3'b001. A following ADD r1=r1+r1 writes 200 and the ADD reads the old r1.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 →
  - `out_valid`=1 with `out_data` and `out_onz` constant.
  - `in_ready`=0; no instruction is accepted.
  - Accept resumes the cycle after `out_ready`=1.
- `rst_n`=0 during EXEC of ADD r3=r1+r2 → next cycle `out_valid`=0, `in_ready`=1. A later ADD r0=r3+r3 returns 0.
- With `ALU_CTRL_STICKY_OVF_EN`: after 100+50, `ovf_sticky`=1 and stays 1 through a SUB with O=0; it returns to 0 only after reset.
